qspi_burst_ctrl: RTL and testbench
==================================

# qspi_burst_ctrl

Parametrised quad/single-SPI memory controller for PSRAM or SPI flash on the KianV SoC memory bus. Adds to the current QSPI controller a programmable SCLK divider, configurable dummy cycles, multi-word read bursts with per-word strobes, a parametrised chip-select field and a guaranteed CE-high deselect time. Sits between the CPU/cache bus and the board SIO pad tristates.

## Interface
- QUAD_MODE, 1, 1 = quad address/data (0xEB read, 0x38 write); 0 = single-bit (0x03 read, 0x02 write)
- PSRAM_SPIFLASH, 1, 1 = PSRAM byte order; 0 = flash (read word byte-swapped)
- CEN_NPOL, 0, XORed onto internal active-low CE to form cen
- CLK_DIV, 1, clk cycles per SCLK half-period (≥1)
- DUMMY_CYCLES, 6, SCLK cycles between address and data on quad reads
- CS_BITS, 2, chip-select width taken from top of addr
- ADDR_W, 23, word-address width (includes CS_BITS)
- MAX_BURST, 8, maximum read words per transaction (power of 2)
- DESEL_CYCLES, 2, minimum clk cycles CE held high between transactions
- BL_W, $clog2(MAX_BURST), burst_len width

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- valid  in  1  request; held until ready
- addr  in  ADDR_W  word address; [ADDR_W-1 -: CS_BITS] = chip select
- wstrb  in  4  byte strobes; 0 = read
- wdata  in  32  write data
- burst_len  in  BL_W  read words minus 1; ignored for writes
- rdata  out  32  read word
- rvalid  out  1  one-cycle pulse per read word
- ready  out  1  one-cycle completion pulse
- cen  out  1  memory chip enable
- cs  out  CS_BITS  registered chip select
- sclk  out  1  SPI clock, idles low
- sio_out  out  4  pad output data
- sio_oe  out  4  pad output enables
- sio_in  in  4  pad input data

## Operation
- Reset values: cen=1^CEN_NPOL, sclk=0, sio_oe=0000, sio_out=0000, cs=0, rdata=0, rvalid=0, ready=0, state IDLE.
- States: IDLE → SELECT → CMD → ADDR → (DUMMY if quad read) → XFER → DONE → DESEL → IDLE.
- IDLE: request accepted when valid=1 and DESEL count expired; addr, wstrb, wdata, burst_len latched.
- SELECT (1 cycle): cs loaded, CE low, sio_oe=0001.
- CMD: 8 SCLK single-bit on sio_out[0], MSB first.
- ADDR: 24-bit byte address {0,addr[20:0],byte_offset} (PSRAM) or {addr[21:0],byte_offset} (flash); 6 SCLK quad, 24 single; sio_oe=1111 (quad) / 0001 (single).
- DUMMY: DUMMY_CYCLES SCLK, sio_oe=0000.
- XFER write: contiguous strobes only; byte_offset = index of highest-address byte per big-endian order (0001→3, 0011→2, 1111→0); bytes = popcount; non-contiguous strobes treated as 1111. 2 or 8 SCLK per byte (quad/single).
- XFER read: (burst_len+1) words, 8 or 32 SCLK each, CE held low throughout; sio_oe=0000; single mode samples sio_in[1].
- Output data changes while SCLK low; input sampled on the clk SCLK rises.
- rdata updated and rvalid pulsed the cycle after each word's final sample; last word: rvalid and ready same cycle (write: ready only).
- DONE→DESEL: CE high, sio_oe=0000, held DESEL_CYCLES cycles.
- Callers must not cross a 1 KB PSRAM page within a burst; not checked.

## Timing
- SCLK period 2·CLK_DIV clk. Total SCLK S = 8 + A + D + W·(burst_len+1), A=6/24, D=DUMMY_CYCLES on quad read else 0, W=8/32 (read) or bytes·2/8 (write).
- ready asserted 2 + 2·CLK_DIV·S cycles after the cycle valid is sampled in IDLE.
- valid must drop the cycle after ready; valid high in the ready cycle is not a new request.
- Async rst mid-transfer: all outputs to reset values immediately; partial transfer abandoned, no ready.
- valid arriving during DESEL waits; request starts the cycle DESEL expires.

## Structure
- Package qspi_pkg: opcode constants, state enum, sio_oe encodings.
- Sub-module qspi_wstrb_align: combinational wstrb → byte_offset, byte count, left-aligned write buffer.
- SCLK divider counter, phase bit counter and word counter live in top module.

## Test plan
- Quad read, CLK_DIV=1, DUMMY=6, burst_len=0, model returns 0xDEADBEEF → S=28, ready at cycle 58, rdata=DEADBEEF, one rvalid.
- Quad read burst_len=3 → four rvalid pulses 16 cycles apart, CE low continuously, words in address order, ready with fourth.
- Quad write wstrb=0100 wdata=0x00AB0000 addr=0x10 → opcode 0x38, byte addr 0x000041, single byte 0xAB, ready.
- QUAD_MODE=0, PSRAM_SPIFLASH=0, CLK_DIV=3: read → opcode 0x03, no dummy, rdata byte-swapped, SCLK period 6 clk.
- rst asserted mid-ADDR → same cycle cen inactive, sclk=0, sio_oe=0; subsequent request completes normally.
- Back-to-back requests → CE high ≥ DESEL_CYCLES between transactions; valid held in ready cycle ignored.

Source files
------------

// File: rtl/qspi_pkg.sv
// qspi_pkg: opcodes, controller states and pad output-enable encodings for qspi_burst_ctrl.
package qspi_pkg;
  localparam logic [7:0] OP_QREAD  = 8'hEB;
  localparam logic [7:0] OP_QWRITE = 8'h38;
  localparam logic [7:0] OP_SREAD  = 8'h03;
  localparam logic [7:0] OP_SWRITE = 8'h02;
  localparam logic [3:0] OE_NONE   = 4'b0000;
  localparam logic [3:0] OE_SINGLE = 4'b0001;
  localparam logic [3:0] OE_QUAD   = 4'b1111;
  typedef enum logic [2:0] {
    S_IDLE, S_SELECT, S_CMD, S_ADDR, S_DUMMY, S_XFER, S_DONE, S_DESEL
  } state_e;
  function automatic logic [31:0] bswap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction
endpackage

// File: rtl/qspi_wstrb_align.sv
// qspi_wstrb_align: maps byte strobes to a start byte offset, byte count and left-aligned write word.
module qspi_wstrb_align (
  input  logic [3:0]  wstrb_i,
  input  logic [31:0] wdata_i,
  output logic [1:0]  byte_off_o,
  output logic [2:0]  bytes_o,
  output logic [31:0] wbuf_o
);
  logic [4:0] s, low;
  logic       contig;
  logic [3:0] strb;
  logic [1:0] hi;
  always_comb begin
    s = {1'b0, wstrb_i};
    low = s & (~s + 5'd1);
    // a run of ones carries cleanly out of its top bit when the lowest set bit is added
    contig = ((s + low) & s) == 5'd0;
    strb = contig ? wstrb_i : 4'b1111;
    hi = 2'd0;
    bytes_o = 3'd0;
    for (int i = 0; i < 4; i++) begin
      hi = strb[i] ? 2'(i) : hi;
      bytes_o = bytes_o + 3'(strb[i]);
    end
    byte_off_o = 2'd3 - hi;
    wbuf_o = wdata_i << {byte_off_o, 3'b000};
  end
endmodule

// File: rtl/qspi_burst_ctrl.sv
// qspi_burst_ctrl: quad/single SPI PSRAM/flash controller with SCLK divider, dummy cycles,
// multi-word read bursts and guaranteed CE-high deselect time.
module qspi_burst_ctrl
  import qspi_pkg::*;
#(
  parameter bit QUAD_MODE      = 1'b1,
  parameter bit PSRAM_SPIFLASH = 1'b1,
  parameter bit CEN_NPOL       = 1'b0,
  parameter int CLK_DIV        = 1,
  parameter int DUMMY_CYCLES   = 6,
  parameter int CS_BITS        = 2,
  parameter int ADDR_W         = 23,
  parameter int MAX_BURST      = 8,
  parameter int DESEL_CYCLES   = 2,
  parameter int BL_W           = $clog2(MAX_BURST)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                valid,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [3:0]          wstrb,
  input  logic [31:0]         wdata,
  input  logic [BL_W-1:0]     burst_len,
  output logic [31:0]         rdata,
  output logic                rvalid,
  output logic                ready,
  output logic                cen,
  output logic [CS_BITS-1:0]  cs,
  output logic                sclk,
  output logic [3:0]          sio_out,
  output logic [3:0]          sio_oe,
  input  logic [3:0]          sio_in
);
  localparam int DIV_W = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  state_e             state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic               sclk_q, sclk_d, wr_q, wr_d, rvalid_q, rvalid_d, ready_q, ready_d;
  logic [7:0]         cnt_q, cnt_d, len_q, len_d, op;
  logic [BL_W-1:0]    words_q, words_d;
  logic [63:0]        tx_q, tx_d;
  logic [31:0]        rx_q, rx_d, rdata_q, rdata_d, wbuf;
  logic [CS_BITS-1:0] cs_q, cs_d;
  logic [1:0]         boff;
  logic [2:0]         nbytes;
  logic [23:0]        baddr;
  logic [3:0]         oe, sio_raw;
  logic               is_wr, shifting, half_end, rise, fall, last;

  qspi_wstrb_align u_align (
    .wstrb_i(wstrb), .wdata_i(wdata), .byte_off_o(boff), .bytes_o(nbytes), .wbuf_o(wbuf)
  );

  always_comb begin
    is_wr = |wstrb;
    op = QUAD_MODE ? (is_wr ? OP_QWRITE : OP_QREAD) : (is_wr ? OP_SWRITE : OP_SREAD);
    baddr = PSRAM_SPIFLASH ? {1'b0, addr[20:0], is_wr ? boff : 2'b00}
                           : {addr[21:0], is_wr ? boff : 2'b00};
    shifting = state_q inside {S_CMD, S_ADDR, S_DUMMY, S_XFER};
    half_end = div_q == DIV_W'(CLK_DIV - 1);
    rise = shifting && half_end && !sclk_q;
    fall = shifting && half_end && sclk_q;
    last = cnt_q == 8'd0;
    state_d = state_q;
    div_d = (shifting && !half_end) ? div_q + DIV_W'(1) : '0;
    sclk_d = rise ? 1'b1 : fall ? 1'b0 : sclk_q;
    cnt_d = fall ? cnt_q - 8'd1 : cnt_q;
    // output data advances on the SCLK fall so it is stable across the whole low half
    tx_d = !fall ? tx_q : (state_q == S_CMD || !QUAD_MODE) ? tx_q << 1 : tx_q << 4;
    rx_d = !(rise && state_q == S_XFER) ? rx_q
         : QUAD_MODE ? {rx_q[27:0], sio_in} : {rx_q[30:0], sio_in[1]};
    words_d = words_q;
    wr_d = wr_q;
    len_d = len_q;
    cs_d = cs_q;
    rdata_d = rdata_q;
    rvalid_d = 1'b0;
    ready_d = 1'b0;
    case (state_q)
      S_IDLE: if (valid) begin
        state_d = S_SELECT;
        tx_d = {op, baddr, wbuf};
        wr_d = is_wr;
        words_d = is_wr ? '0 : burst_len;
        cs_d = addr[ADDR_W-1 -: CS_BITS];
        len_d = is_wr ? (QUAD_MODE ? {4'b0, nbytes, 1'b0} : {2'b0, nbytes, 3'b000})
                      : (QUAD_MODE ? 8'd8 : 8'd32);
      end
      S_SELECT: begin
        state_d = S_CMD;
        cnt_d = 8'd7;
      end
      S_CMD: if (fall && last) begin
        state_d = S_ADDR;
        cnt_d = QUAD_MODE ? 8'd5 : 8'd23;
      end
      S_ADDR: if (fall && last) begin
        if (QUAD_MODE && !wr_q && DUMMY_CYCLES > 0) begin
          state_d = S_DUMMY;
          cnt_d = 8'(DUMMY_CYCLES - 1);
        end else begin
          state_d = S_XFER;
          cnt_d = len_q - 8'd1;
        end
      end
      S_DUMMY: if (fall && last) begin
        state_d = S_XFER;
        cnt_d = len_q - 8'd1;
      end
      S_XFER: if (fall && last) begin
        rvalid_d = !wr_q;
        rdata_d = wr_q ? rdata_q : PSRAM_SPIFLASH ? rx_q : bswap32(rx_q);
        if (wr_q || words_q == '0) begin
          state_d = S_DONE;
          ready_d = 1'b1;
        end else begin
          words_d = words_q - BL_W'(1);
          cnt_d = len_q - 8'd1;
        end
      end
      S_DONE: begin
        state_d = S_DESEL;
        cnt_d = DESEL_CYCLES > 0 ? 8'(DESEL_CYCLES - 1) : 8'd0;
      end
      S_DESEL: begin
        state_d = last ? S_IDLE : S_DESEL;
        cnt_d = last ? cnt_q : cnt_q - 8'd1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q  <= S_IDLE;
      div_q    <= '0;
      sclk_q   <= 1'b0;
      cnt_q    <= '0;
      words_q  <= '0;
      tx_q     <= '0;
      rx_q     <= '0;
      wr_q     <= 1'b0;
      len_q    <= '0;
      cs_q     <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      sclk_q   <= sclk_d;
      cnt_q    <= cnt_d;
      words_q  <= words_d;
      tx_q     <= tx_d;
      rx_q     <= rx_d;
      wr_q     <= wr_d;
      len_q    <= len_d;
      cs_q     <= cs_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      ready_q  <= ready_d;
    end

  always_comb begin
    oe = (state_q == S_SELECT || state_q == S_CMD) ? OE_SINGLE
       : (state_q == S_ADDR || (state_q == S_XFER && wr_q)) ? (QUAD_MODE ? OE_QUAD : OE_SINGLE)
       : OE_NONE;
    sio_raw = (state_q == S_CMD || !QUAD_MODE) ? {3'b000, tx_q[63]} : tx_q[63:60];
  end

  assign sio_oe  = oe;
  assign sio_out = sio_raw & oe;
  assign cen     = !(state_q inside {S_SELECT, S_CMD, S_ADDR, S_DUMMY, S_XFER}) ^ CEN_NPOL;
  assign cs      = cs_q;
  assign sclk    = sclk_q;
  assign rdata   = rdata_q;
  assign rvalid  = rvalid_q;
  assign ready   = ready_q;
endmodule

// File: tb/tb_qspi_burst_ctrl.sv
// tb_qspi_burst_ctrl: directed bench with behavioural SPI memory models for a quad PSRAM
// instance (CLK_DIV=1) and a single-bit flash instance (CLK_DIV=3).
module tb_qspi_burst_ctrl;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;

  logic        v0 = 1'b0, v1 = 1'b0;
  logic [22:0] a0 = '0, a1 = '0;
  logic [3:0]  ws0 = '0, ws1 = '0, si0 = '0, si1 = '0;
  logic [31:0] wd0 = '0, wd1 = '0, rd0, rd1;
  logic [2:0]  bl0 = '0, bl1 = '0;
  logic        rv0, rv1, rdy0, rdy1, cen0, cen1, sclk0, sclk1;
  logic [1:0]  cs0, cs1;
  logic [3:0]  so0, so1, oe0, oe1;
  int vectors = 0, miscompares = 0;

  qspi_burst_ctrl u0 (
    .clk(clk), .rst(rst), .valid(v0), .addr(a0), .wstrb(ws0), .wdata(wd0), .burst_len(bl0),
    .rdata(rd0), .rvalid(rv0), .ready(rdy0), .cen(cen0), .cs(cs0), .sclk(sclk0),
    .sio_out(so0), .sio_oe(oe0), .sio_in(si0)
  );
  qspi_burst_ctrl #(.QUAD_MODE(1'b0), .PSRAM_SPIFLASH(1'b0), .CLK_DIV(3)) u1 (
    .clk(clk), .rst(rst), .valid(v1), .addr(a1), .wstrb(ws1), .wdata(wd1), .burst_len(bl1),
    .rdata(rd1), .rvalid(rv1), .ready(rdy1), .cen(cen1), .cs(cs1), .sclk(sclk1),
    .sio_out(so1), .sio_oe(oe1), .sio_in(si1)
  );

  // quad PSRAM model: 8 cmd bits, 6 address nibbles, 6 dummy, then data nibbles
  int n0 = 0, wnib0 = 0, j0 = 0;
  logic [7:0]  cmd0 = '0;
  logic [23:0] adr0 = '0;
  logic [31:0] wcap0 = '0;
  logic [31:0] rmem0 [0:7];
  always @(negedge cen0) begin n0 = 0; cmd0 = '0; adr0 = '0; wcap0 = '0; wnib0 = 0; end
  always @(posedge sclk0) begin
    if (n0 < 8) cmd0 = {cmd0[6:0], so0[0]};
    else if (n0 < 14) adr0 = {adr0[19:0], so0};
    else if (cmd0 == 8'h38) begin wcap0 = {wcap0[27:0], so0}; wnib0++; end
    n0++;
  end
  always @(negedge sclk0)
    if (n0 >= 20 && cmd0 == 8'hEB) begin
      j0 = n0 - 20;
      si0 = 4'(rmem0[(j0 / 8) % 8] >> (28 - 4 * (j0 % 8)));
    end

  // single-bit flash model: 8 cmd bits, 24 address bits, 32 data bits on sio_in[1]
  int n1 = 0;
  time t1 = 0, per1 = 0;
  logic [7:0]  cmd1 = '0;
  logic [23:0] adr1 = '0;
  logic [31:0] rmem1 = '0;
  always @(negedge cen1) begin n1 = 0; cmd1 = '0; adr1 = '0; end
  always @(posedge sclk1) begin
    if (n1 == 0) t1 = $time;
    if (n1 == 1) per1 = $time - t1;
    if (n1 < 8) cmd1 = {cmd1[6:0], so1[0]};
    else if (n1 < 32) adr1 = {adr1[22:0], so1[0]};
    n1++;
  end
  always @(negedge sclk1)
    if (n1 >= 32 && n1 < 64 && cmd1 == 8'h03) si1 = {2'b00, rmem1[63 - n1], 1'b0};

  int r_cyc, r_first_low, r_nrv, r_cen_hi;
  int r_rv_cyc [0:7];
  logic [31:0] r_rdata [0:7];

  // drives one request on u0; cycle numbers count from the cycle valid is first raised
  task automatic run0(input logic [22:0] a, input logic [3:0] ws, input logic [31:0] wd,
                      input logic [2:0] bl, input int stop_at);
    v0 = 1'b1; a0 = a; ws0 = ws; wd0 = wd; bl0 = bl;
    r_cyc = 0; r_first_low = 0; r_nrv = 0; r_cen_hi = 0;
    for (int c = 1; c <= 1000; c++) begin
      @(negedge clk);
      if (!cen0 && r_first_low == 0) r_first_low = c;
      if (cen0 && r_first_low != 0 && !rdy0) r_cen_hi++;
      if (rv0 && r_nrv < 8) begin r_rv_cyc[r_nrv] = c; r_rdata[r_nrv] = rd0; r_nrv++; end
      if (c == stop_at) return;
      if (rdy0) begin
        r_cyc = c;
        @(negedge clk);
        v0 = 1'b0;
        return;
      end
    end
    vectors++; miscompares++;
    $display("FAIL run0_timeout: ready not seen in 1000 cycles, required a ready pulse");
    v0 = 1'b0;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    vectors++;
    if ({cen0, sclk0, oe0, so0, cs0, rv0, rdy0} !== {1'b1, 1'b0, 4'h0, 4'h0, 2'b00, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_pins: got cen=%b sclk=%b oe=%h out=%h cs=%b rv=%b rdy=%b, required 1 0 0 0 00 0 0",
               cen0, sclk0, oe0, so0, cs0, rv0, rdy0);
    end
    vectors++;
    if (rd0 !== 32'h0) begin miscompares++; $display("FAIL reset_rdata: got %h required 00000000", rd0); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_quad_read;
    rmem0[0] = 32'hDEADBEEF;
    run0(23'h000100, 4'h0, 32'h0, 3'd0, 0);
    vectors++;
    if (r_cyc !== 58) begin miscompares++; $display("FAIL qread_ready_cycle: got %0d required 58", r_cyc); end
    vectors++;
    if (r_nrv !== 1 || r_rv_cyc[0] !== 58) begin
      miscompares++; $display("FAIL qread_rvalid: got %0d pulses first at %0d, required 1 at 58", r_nrv, r_rv_cyc[0]);
    end
    vectors++;
    if (r_rdata[0] !== 32'hDEADBEEF) begin miscompares++; $display("FAIL qread_rdata: got %h required deadbeef", r_rdata[0]); end
    vectors++;
    if (cmd0 !== 8'hEB || adr0 !== 24'h000400) begin
      miscompares++; $display("FAIL qread_cmd_addr: got %h/%h required eb/000400", cmd0, adr0);
    end
    vectors++;
    if (r_first_low !== 1 || r_cen_hi !== 0) begin
      miscompares++; $display("FAIL qread_ce: got first_low=%0d gaps=%0d required 1/0", r_first_low, r_cen_hi);
    end
  endtask

  task automatic test_burst;
    logic [31:0] exp_w [0:3];
    exp_w[0] = 32'h11111111; exp_w[1] = 32'h22222222; exp_w[2] = 32'h33333333; exp_w[3] = 32'h44444444;
    for (int k = 0; k < 4; k++) rmem0[k] = exp_w[k];
    repeat (4) @(negedge clk);
    run0(23'h400020, 4'h0, 32'h0, 3'd3, 0);
    vectors++;
    if (r_cyc !== 106 || r_nrv !== 4) begin
      miscompares++; $display("FAIL burst_ready: got cycle %0d with %0d rvalids, required 106 with 4", r_cyc, r_nrv);
    end
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (r_rv_cyc[k] !== 58 + 16 * k || r_rdata[k] !== exp_w[k]) begin
        miscompares++;
        $display("FAIL burst_word%0d: got %h at %0d required %h at %0d", k, r_rdata[k], r_rv_cyc[k], exp_w[k], 58 + 16 * k);
      end
    end
    vectors++;
    if (r_cen_hi !== 0 || cs0 !== 2'b10 || adr0 !== 24'h000080) begin
      miscompares++; $display("FAIL burst_ce_cs_addr: got gaps=%0d cs=%b addr=%h required 0/10/000080", r_cen_hi, cs0, adr0);
    end
  endtask

  task automatic test_quad_write;
    logic [3:0]  t_ws  [0:2] = '{4'b0100, 4'b0011, 4'b0101};
    logic [31:0] t_wd  [0:2] = '{32'h00AB0000, 32'h12345678, 32'h12345678};
    logic [23:0] t_adr [0:2] = '{24'h000041, 24'h000042, 24'h000040};
    logic [31:0] t_dat [0:2] = '{32'h000000AB, 32'h00005678, 32'h12345678};
    int          t_nib [0:2] = '{2, 4, 8};
    int          t_cyc [0:2] = '{34, 38, 46};
    for (int k = 0; k < 3; k++) begin
      repeat (4) @(negedge clk);
      run0(23'h000010, t_ws[k], t_wd[k], 3'd7, 0);
      vectors++;
      if (cmd0 !== 8'h38 || adr0 !== t_adr[k]) begin
        miscompares++; $display("FAIL write%0d_cmd_addr: got %h/%h required 38/%h", k, cmd0, adr0, t_adr[k]);
      end
      vectors++;
      if (wcap0 !== t_dat[k] || wnib0 !== t_nib[k]) begin
        miscompares++;
        $display("FAIL write%0d_data: got %h in %0d nibbles required %h in %0d", k, wcap0, wnib0, t_dat[k], t_nib[k]);
      end
      vectors++;
      if (r_cyc !== t_cyc[k] || r_nrv !== 0) begin
        miscompares++; $display("FAIL write%0d_ready: got cycle %0d rvalids %0d required %0d/0", k, r_cyc, r_nrv, t_cyc[k]);
      end
    end
  endtask

  task automatic test_single_flash;
    int cyc = 0, nrv = 0;
    logic [31:0] got = '0;
    rmem1 = 32'h11223344;
    @(negedge clk);
    v1 = 1'b1; a1 = 23'h000040;
    for (int c = 1; c <= 1000 && cyc == 0; c++) begin
      @(negedge clk);
      if (rv1) begin nrv++; got = rd1; end
      if (rdy1) cyc = c;
    end
    @(negedge clk);
    v1 = 1'b0;
    vectors++;
    if (cyc !== 386 || nrv !== 1) begin
      miscompares++; $display("FAIL flash_ready: got cycle %0d rvalids %0d required 386/1", cyc, nrv);
    end
    vectors++;
    if (got !== 32'h44332211) begin miscompares++; $display("FAIL flash_rdata: got %h required 44332211", got); end
    vectors++;
    if (cmd1 !== 8'h03 || adr1 !== 24'h000100) begin
      miscompares++; $display("FAIL flash_cmd_addr: got %h/%h required 03/000100", cmd1, adr1);
    end
    vectors++;
    if (per1 !== 60) begin miscompares++; $display("FAIL flash_sclk_period: got %0t required 60", per1); end
  endtask

  task automatic test_reset_mid;
    repeat (4) @(negedge clk);
    rmem0[0] = 32'h0BADF00D;
    run0(23'h000100, 4'h0, 32'h0, 3'd0, 19);
    vectors++;
    if (sclk0 !== 1'b1 || oe0 !== 4'hF) begin
      miscompares++; $display("FAIL rstmid_pre: got sclk=%b oe=%h required 1/f", sclk0, oe0);
    end
    rst = 1'b1; v0 = 1'b0;
    #1;
    vectors++;
    if ({cen0, sclk0, oe0, so0, rdy0} !== {1'b1, 1'b0, 4'h0, 4'h0, 1'b0}) begin
      miscompares++; $display("FAIL rstmid_pins: got cen=%b sclk=%b oe=%h out=%h rdy=%b required 1 0 0 0 0",
                             cen0, sclk0, oe0, so0, rdy0);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rmem0[0] = 32'hCAFEF00D;
    run0(23'h000100, 4'h0, 32'h0, 3'd0, 0);
    vectors++;
    if (r_cyc !== 58 || r_rdata[0] !== 32'hCAFEF00D) begin
      miscompares++; $display("FAIL rstmid_after: got %h at %0d required cafef00d at 58", r_rdata[0], r_cyc);
    end
  endtask

  task automatic test_back_to_back;
    int low = 0;
    repeat (4) @(negedge clk);
    rmem0[0] = 32'hA5A55A5A;
    run0(23'h000200, 4'h0, 32'h0, 3'd0, 0);
    vectors++;
    if (r_cyc !== 58 || r_rdata[0] !== 32'hA5A55A5A) begin
      miscompares++; $display("FAIL b2b_first: got %h at %0d required a5a55a5a at 58", r_rdata[0], r_cyc);
    end
    @(negedge clk);
    rmem0[0] = 32'h0F1E2D3C;
    run0(23'h000201, 4'h0, 32'h0, 3'd0, 0);
    vectors++;
    if (r_first_low !== 2 || r_cyc !== 59 || r_rdata[0] !== 32'h0F1E2D3C) begin
      miscompares++;
      $display("FAIL b2b_second: got ce_low=%0d ready=%0d data=%h required 2/59/0f1e2d3c", r_first_low, r_cyc, r_rdata[0]);
    end
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (!cen0) low++;
    end
    vectors++;
    if (low !== 0) begin miscompares++; $display("FAIL b2b_ready_cycle_valid: got %0d CE-low cycles required 0", low); end
  endtask

  initial begin
    test_reset;
    test_quad_read;
    test_burst;
    test_quad_write;
    test_single_flash;
    test_reset_mid;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
